// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// lane-size helpers, the captured-request payload and the access error check.
package lsu_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned F3_W          = 3;
  localparam int unsigned DEF_MEM_WORDS = 256;

  // RV32I load funct3
  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;
  // RV32I store funct3
  localparam logic [F3_W-1:0] F3_SB  = 3'b000;
  localparam logic [F3_W-1:0] F3_SH  = 3'b001;
  localparam logic [F3_W-1:0] F3_SW  = 3'b010;

  // Access size lives in funct3[1:0]; funct3[2] marks an unsigned load.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RMW_RD = 2'd2,
    ST_WRITE  = 2'd3
  } lsu_state_t;

  // Request payload held for the duration of an access.
  typedef struct packed {
    logic [F3_W-1:0] funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } lsu_txn_t;

  // Misaligned, unsupported funct3 for the direction, or beyond the memory.
  function automatic logic access_err(input logic            write,
                                      input logic [F3_W-1:0] funct3,
                                      input logic [XLEN-1:0] addr,
                                      input int unsigned     mem_words);
    logic f3_ok;
    logic misaligned;
    logic out_of_range;
    if (write) f3_ok = funct3 inside {F3_SB, F3_SH, F3_SW};
    else       f3_ok = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    misaligned   = ((funct3[1:0] == SIZE_HALF) && addr[0]) ||
                   ((funct3[1:0] == SIZE_WORD) && (addr[1:0] != 2'b00));
    out_of_range = addr >= XLEN'(4 * mem_words);
    return !f3_ok || misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the load/store unit.
//  funct3     in  3   access funct3 (size in [1:0], unsigned in [2])
//  byte_off   in  2   addr[1:0] of the access
//  word       in  32  word read from memory
//  wdata      in  32  store data (low lanes for SB/SH)
//  load_data  out 32  extracted and sign/zero-extended load result
//  store_word out 32  memory word with the addressed lane replaced
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [F3_W-1:0] funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        signed_ld;

  // Load: pick the lane and extend.
  always_comb begin
    byte_sel  = word[{byte_off, 3'b000} +: 8];
    half_sel  = byte_off[1] ? word[31:16] : word[15:0];
    signed_ld = ~funct3[2];
    case (funct3[1:0])
      SIZE_BYTE: load_data = {{24{signed_ld & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data = {{16{signed_ld & half_sel[15]}}, half_sel};
      default:   load_data = word;
    endcase
  end

  // Store: merge the new lane into the existing word.
  always_comb begin
    store_word = word;
    case (funct3[1:0])
      SIZE_BYTE: store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
      SIZE_HALF: begin
        if (byte_off[1]) store_word[31:16] = wdata[15:0];
        else             store_word[15:0]  = wdata[15:0];
      end
      default:   store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage access controller for RV32I loads/stores to a word-only memory.
//  clk, rst_n                   clock, async active-low reset
//  req_valid/req_ready          request handshake (ready only when idle)
//  req_write/funct3/addr/wdata  request payload, captured on acceptance
//  rsp_valid/rsp_rdata/rsp_err  one-cycle completion pulse with result/error
//  mem_addr/mem_write_data      word address and write word to memory
//  mem_read/mem_write           memory enables, decoded from state
//  mem_read_data                combinational memory read word
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [F3_W-1:0] req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_read,
  output logic            mem_write,
  input  logic [XLEN-1:0] mem_read_data
);

  lsu_state_t      state_q, state_d;
  lsu_txn_t        txn_q, txn_d;
  logic            rsp_valid_d;
  logic            rsp_err_d;
  logic [XLEN-1:0] rsp_rdata_d;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_word;

  lsu_lane_align u_align (
    .funct3     (txn_q.funct3),
    .byte_off   (txn_q.addr[1:0]),
    .word       (mem_read_data),
    .wdata      (txn_q.data),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      txn_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      txn_q     <= txn_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

  // Next state and registered response.
  always_comb begin
    state_d     = state_q;
    txn_d       = txn_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          txn_d.funct3 = req_funct3;
          txn_d.addr   = req_addr;
          txn_d.data   = req_wdata;
          if (access_err(req_write, req_funct3, req_addr, MEM_WORDS)) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (!req_write) begin
            state_d = ST_LOAD;
          end else if (req_funct3[1:0] == SIZE_WORD) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_LOAD: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_data;
        state_d     = ST_IDLE;
      end
      ST_RMW_RD: begin
        // Merged word replaces the store data so WRITE handles all stores alike.
        txn_d.data = store_word;
        state_d    = ST_WRITE;
      end
      ST_WRITE: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign mem_read       = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
  assign mem_write      = (state_q == ST_WRITE);
  assign mem_addr       = {txn_q.addr[XLEN-1:2], 2'b00};
  assign mem_write_data = txn_q.data;

endmodule
